// File: rtl/hpu_vram_arbiter.sv
// VRAM arbiter: shares one single-port VRAM between the tile fetcher and the host port.
// Tile fetcher owns active display, host owns blanking, with a starvation guard for the host.
module hpu_vram_arbiter #(
    parameter int MAX_WAIT = 64,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              tile_req,
    input  logic [ADDR_W-1:0] tile_addr,
    output logic              tile_gnt,
    output logic              tile_valid,
    output logic [7:0]        tile_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              host_starved
);

    localparam logic [1:0] H_IDLE = 2'd0;
    localparam logic [1:0] H_WR   = 2'd1;
    localparam logic [1:0] H_RD   = 2'd2;
    localparam logic [1:0] H_DONE = 2'd3;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [1:0] host_state_reg, host_state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    // Read-source tags per issued slot: {valid_read, is_host}
    logic [1:0] tag0_reg, tag1_reg;
    logic       host_eligible, force_slot, host_win;
    logic       tile_ret, host_ret;

    // Reset gates the combinational grants so every output reads 0 while reset is held.
    always_comb begin
        host_eligible = !reset && host_req && (host_state_reg == H_IDLE);
        force_slot    = host_eligible && (wait_cnt_reg == WAIT_LIMIT);
        host_win      = host_eligible && (!active || !tile_req || force_slot);
        tile_gnt      = !reset && tile_req && !host_win;
        host_starved  = force_slot && host_win;
        tile_ret      = tag1_reg[1] && !tag1_reg[0];
        host_ret      = tag1_reg[1] && tag1_reg[0];
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!host_req || host_win) begin
            wait_cnt_next = 8'd0;
        end else if (host_eligible && (wait_cnt_reg != WAIT_LIMIT)) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    // H_DONE is entered only after the ack cycle, so a held host_req cannot re-win immediately.
    always_comb begin
        host_state_next = host_state_reg;
        case (host_state_reg)
            H_IDLE: if (host_win) host_state_next = host_we ? H_WR : H_RD;
            H_WR:   host_state_next = H_DONE;
            H_RD:   if (host_ack) host_state_next = H_DONE;
            default: host_state_next = H_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_state_reg <= H_IDLE;
            wait_cnt_reg   <= 8'd0;
            tag0_reg       <= 2'b00;
            tag1_reg       <= 2'b00;
            mem_addr       <= '0;
            mem_we         <= 1'b0;
            mem_wdata      <= 8'd0;
            tile_valid     <= 1'b0;
            tile_data      <= 8'd0;
            host_ack       <= 1'b0;
            host_rdata     <= 8'd0;
        end else begin
            host_state_reg <= host_state_next;
            wait_cnt_reg   <= wait_cnt_next;
            mem_we         <= 1'b0;
            if (host_win) begin
                mem_addr  <= host_addr;
                mem_we    <= host_we;
                mem_wdata <= host_wdata;
            end else if (tile_gnt) begin
                mem_addr  <= tile_addr;
            end
            tag0_reg   <= {host_win ? !host_we : tile_gnt, host_win};
            tag1_reg   <= tag0_reg;
            tile_valid <= tile_ret;
            if (tile_ret) begin
                tile_data <= mem_rdata;
            end
            // Writes ack on issue; reads ack when their tagged slot returns.
            host_ack <= host_ret || (host_win && host_we);
            if (host_ret) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/hpu_vram_arbiter.md
Name: hpu_vram_arbiter

Overview:
- Shares the single-port 64 KiB VRAM between two requesters: the tile fetcher (pixel pipeline) and a host read/write port used for tile, map and palette uploads.
- The tile fetcher wins during active display. The host wins during blanking.
- A starvation guard forces one host slot after MAX_WAIT consecutive denied cycles.
- Sits between the tile engine's addr/data bus and the VRAM macro.

Parameters:
- MAX_WAIT, 64: host pending cycles before a host slot is forced; range 1..255.
- ADDR_W, 16: VRAM address width.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- active  in  1  high while the beam is inside the visible window (x<512, y<480)
- tile_req  in  1  tile fetcher read request
- tile_addr  in  ADDR_W  tile fetcher read address
- tile_gnt  out  1  combinational; tile request accepted this cycle
- tile_valid  out  1  one-cycle pulse; tile_data valid
- tile_data  out  8  read data for the tile fetcher
- host_req  in  1  host request; held with addr/we/wdata stable until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle pulse; transaction complete
- host_rdata  out  8  host read data; valid with host_ack on reads
- mem_addr  out  ADDR_W  registered VRAM address
- mem_we  out  1  registered VRAM write enable
- mem_wdata  out  8  registered VRAM write data
- mem_rdata  in  8  VRAM read data; valid the cycle after mem_addr is driven
- host_starved  out  1  one-cycle pulse when a host slot is forced

Behaviour:
- Reset: all outputs 0; wait counter 0; host FSM H_IDLE; in-flight reads discarded with no valid or ack pulse. This holds when reset is asserted mid-transaction.
- Arbitration (combinational, cycle N):
  - host_eligible = host_req && host FSM == H_IDLE.
  - force = host_eligible && wait_cnt == MAX_WAIT.
  - host_win = host_eligible && (!active || !tile_req || force).
  - tile_gnt = tile_req && !host_win.
- Issue: at edge N+1, mem_addr/mem_we/mem_wdata load from the winner. With no winner: mem_we=0 and mem_addr holds its value.
- Tile reads are fully pipelined, one per cycle. Request granted in cycle 0 -> tile_valid and tile_data in cycle 3 (mem_addr cycle 1, mem_rdata cycle 2, registered at edge 3).
- Read-source tag: a 2-stage shift register carries {valid, is_host} for each issued slot, so returning data is routed to the correct requester.
- Host FSM:
  - H_IDLE -> H_WR on a write win: mem_we=1 in cycle 1, host_ack in cycle 1, -> H_DONE.
  - H_IDLE -> H_RD on a read win: host_ack and host_rdata in cycle 3, -> H_DONE.
  - H_DONE lasts one cycle, then -> H_IDLE. Host_req still high in H_DONE is ignored, so a back-to-back host transaction issues at the earliest 2 cycles after ack.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle host_eligible && !host_win.
  - Clears on host_win or when host_req is low.
  - host_starved pulses in the cycle force && host_win.
- tile_req is level-held by the fetcher until tile_gnt. A denied cycle stalls the fetcher; the arbiter never drops a granted read.
- Simultaneous tile_req and host_req:
  - active=1: tile wins unless force.
  - active=0: host wins.
- Outside active display, tile reads are still served whenever the host is idle.
- Host write then tile read to the same address in the next cycle returns the new data, since the VRAM is write-first and ordering is by issue cycle.
- tile_valid and host_ack never assert in the same cycle for the same slot. Each slot has exactly one owner.

Test Plan:
- Tile stream: active=1, tile_req held high, tile_addr 0x0100..0x0107 on consecutive cycles, VRAM preloaded with addr[7:0] -> tile_gnt=1 for all 8 cycles; tile_valid on cycles 3..10 with data 0x00..0x07 in order.
- Host write in blanking: active=0, host_we=1, addr 0x2000, wdata 0xA5, with tile_req high -> host wins; mem_we=1, mem_addr=0x2000 in cycle 1; host_ack cycle 1; tile_gnt=0 in cycle 0 only. A subsequent host read of 0x2000 -> host_ack with host_rdata 0xA5, 3 cycles after issue.
- Starvation: MAX_WAIT=4, active=1, tile_req constantly high, host read of 0x0010 -> tile_gnt low only in cycle 4; host_starved pulses in cycle 4; host_ack in cycle 7; all other tile reads return correctly.
- Back-to-back host: host_req held high over 2 reads -> the second read issues no earlier than 2 cycles after the first host_ack; there is never a double ack.
- Reset mid-read: assert reset 1 cycle after a host read issues -> all outputs 0 immediately; no host_ack or tile_valid after reset release; the next host read completes normally with 3-cycle latency.
